// File: rtl/noc_tile_injector.sv
// Tile-side injector for a mesh router local port. It queues validated multi-word messages
// and serialises them into 64-bit flits that carry a {row, col} route header.
//
// state  | meaning
// S_IDLE | no flit on the output; pops the next queued message as soon as one exists
// S_SEND | a flit is on the output and held until flit_ready_i; chains messages without bubbles
module noc_tile_injector #(
  parameter int ROWS        = 2,
  parameter int COLS        = 2,
  parameter int MAX_FLITS   = 4,
  parameter int REQ_DEPTH   = 2,
  parameter int STALL_LIMIT = 64,
  localparam int LEN_W      = $clog2(MAX_FLITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [7:0]              req_dest_row_i,
  input  logic [7:0]              req_dest_col_i,
  input  logic [LEN_W-1:0]        req_len_i,
  input  logic [MAX_FLITS*46-1:0] req_payload_i,
  output logic [63:0]             flit_o,
  output logic                    flit_valid_o,
  input  logic                    flit_ready_i,
  output logic                    busy_o,
  output logic                    stall_o,
  output logic [15:0]             err_cnt_o,
  output logic [31:0]             pkt_cnt_o
);

  localparam int PL_W  = MAX_FLITS * 46;
  localparam int ENT_W = 16 + LEN_W + PL_W;
  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);
  localparam int STL_W = $clog2(STALL_LIMIT + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(REQ_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(REQ_DEPTH);
  localparam logic [STL_W-1:0] STALL_C  = STL_W'(STALL_LIMIT);
  localparam logic [LEN_W-1:0] MAXLEN_C = LEN_W'(MAX_FLITS);
  localparam logic [LEN_W-1:0] ONE_C    = LEN_W'(1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t state, state_nxt;

  logic [ENT_W-1:0] mem [REQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             req_hs, req_legal, push, pop, load_next, drop_valid;

  logic [7:0]       head_row, head_col;
  logic [LEN_W-1:0] head_len;
  logic [PL_W-1:0]  head_pl;

  logic [7:0]       cur_row, cur_col;
  logic [LEN_W-1:0] cur_len, idx;
  logic [PL_W-1:0]  cur_pl;
  logic             flit_hs, last_hs;

  logic [STL_W-1:0] stall_cnt, stall_cnt_nxt;

  function automatic logic [63:0] make_flit(input logic [7:0]       row,
                                            input logic [7:0]       col,
                                            input logic [LEN_W-1:0] len,
                                            input logic [LEN_W-1:0] k,
                                            input logic [PL_W-1:0]  pl);
    logic [1:0]  ftype;
    int unsigned off;
    if (len == ONE_C)            ftype = 2'b11;
    else if (k == '0)            ftype = 2'b01;
    else if (k == len - ONE_C)   ftype = 2'b10;
    else                         ftype = 2'b00;
    off = 32'(k) * 46;
    return {ftype, pl[off +: 46], row, col};
  endfunction

  assign fifo_full   = (fifo_cnt == DEPTH_C);
  assign fifo_empty  = (fifo_cnt == '0);
  assign req_ready_o = !fifo_full;
  assign req_hs      = req_valid_i & req_ready_o;
  assign req_legal   = (req_len_i != '0) && (req_len_i <= MAXLEN_C) &&
                       (req_dest_row_i < 8'(ROWS)) && (req_dest_col_i < 8'(COLS));
  assign push        = req_hs & req_legal;

  assign {head_row, head_col, head_len, head_pl} = mem[rd_ptr];

  assign flit_hs = flit_valid_o & flit_ready_i;
  assign last_hs = flit_hs && (idx == cur_len - ONE_C);
  assign busy_o  = !fifo_empty || (state == S_SEND);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_dest_row_i, req_dest_col_i, req_len_i, req_payload_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_SEND;
      S_SEND:  if (last_hs && fifo_empty) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    load_next  = 1'b0;
    drop_valid = 1'b0;
    case (state)
      S_IDLE: pop = !fifo_empty;
      S_SEND: begin
        if (flit_hs) begin
          if (!last_hs)         load_next  = 1'b1;
          else if (!fifo_empty) pop        = 1'b1;
          else                  drop_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_row      <= '0;
      cur_col      <= '0;
      cur_len      <= '0;
      cur_pl       <= '0;
      idx          <= '0;
      flit_o       <= '0;
      flit_valid_o <= 1'b0;
    end else if (pop) begin
      cur_row      <= head_row;
      cur_col      <= head_col;
      cur_len      <= head_len;
      cur_pl       <= head_pl;
      idx          <= '0;
      flit_o       <= make_flit(head_row, head_col, head_len, '0, head_pl);
      flit_valid_o <= 1'b1;
    end else if (load_next) begin
      idx          <= idx + ONE_C;
      flit_o       <= make_flit(cur_row, cur_col, cur_len, idx + ONE_C, cur_pl);
    end else if (drop_valid) begin
      flit_valid_o <= 1'b0;
    end
  end

  // Stall run length saturates at the limit; any handshake or idle output restarts it.
  always_comb begin
    stall_cnt_nxt = '0;
    if (flit_valid_o && !flit_ready_i)
      stall_cnt_nxt = (stall_cnt == STALL_C) ? stall_cnt : stall_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      stall_o   <= 1'b0;
      err_cnt_o <= '0;
      pkt_cnt_o <= '0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      stall_o   <= (stall_cnt_nxt == STALL_C);
      if (req_hs && !req_legal && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 1'b1;
      if (last_hs) pkt_cnt_o <= pkt_cnt_o + 1'b1;
    end
  end

endmodule
